// File: rtl/edge_frame_collector_if.sv
// edge_frame_collector_if
// Ready/valid output stream carrying tagged edge pixels.
//   m_data  : 8-bit pixel
//   m_sof   : pixel is row 0, col 0
//   m_eol   : pixel is the last column of a line
//   m_eof   : pixel is the last pixel of a frame
//   m_valid : beat available (source -> sink)
//   m_ready : sink accepts (sink -> source)
// Modports: master (collector side), slave (downstream side).
interface edge_frame_collector_if;
   logic [7:0] m_data;
   logic       m_sof;
   logic       m_eol;
   logic       m_eof;
   logic       m_valid;
   logic       m_ready;

   modport master (
      output m_data, m_sof, m_eol, m_eof, m_valid,
      input  m_ready
   );

   modport slave (
      input  m_data, m_sof, m_eol, m_eof, m_valid,
      output m_ready
   );
endinterface

// File: rtl/edge_frame_collector.sv
// edge_frame_collector
// Receive-side sink for a free-running edge-pixel stream. Every valid input
// pixel advances a column/row position inside an IMG_W x IMG_H frame; the
// pixel is tagged (sof/eol/eof) from that position and pushed into a
// show-ahead FIFO that feeds a ready/valid output. The input cannot be
// stalled, so a pixel arriving on a full FIFO is dropped and the sticky
// overflow flag is raised; the position counters advance regardless so
// later pixels keep their frame coordinates.
//
// Ports:
//   clk            : clock, rising edge
//   rstN           : asynchronous active-low reset
//   pixel_in       : 8-bit edge pixel
//   pixel_in_valid : pixel_in valid this cycle (no backpressure)
//   m              : edge_frame_collector_if.master output stream
//   overflow       : sticky, at least one input pixel was dropped
//   frame_done     : one-cycle pulse after the m_eof beat transfers
//   edge_count     : nonzero pixels in the last complete input frame
//
// Optional feature macro: EDGE_COUNT_EN
//   defined   -> per-frame nonzero pixel counter drives edge_count
//   undefined -> edge_count is tied to zero
module edge_frame_collector #(
   parameter int IMG_W      = 512,
   parameter int IMG_H      = 512,
   parameter int FIFO_DEPTH = 16,
   localparam int ECW       = $clog2(IMG_W * IMG_H + 1)
) (
   input  logic                   clk,
   input  logic                   rstN,
   input  logic [7:0]             pixel_in,
   input  logic                   pixel_in_valid,
   edge_frame_collector_if.master m,
   output logic                   overflow,
   output logic                   frame_done,
   output logic [ECW-1:0]         edge_count
);

   // Degenerate 1-wide / 1-high frames still need a 1-bit counter.
   localparam int CW = (IMG_W > 1) ? $clog2(IMG_W) : 1;
   localparam int RW = (IMG_H > 1) ? $clog2(IMG_H) : 1;
   localparam int AW = $clog2(FIFO_DEPTH);
   localparam int NW = $clog2(FIFO_DEPTH + 1);

   localparam logic [CW-1:0] COL_LAST = CW'(IMG_W - 1);
   localparam logic [RW-1:0] ROW_LAST = RW'(IMG_H - 1);
   localparam logic [NW-1:0] FULL_CNT = NW'(FIFO_DEPTH);

   // FIFO entry layout: {pixel[10:3], sof[2], eol[1], eof[0]}
   logic [CW-1:0] col_r;
   logic [RW-1:0] row_r;
   logic [10:0]   mem_r [FIFO_DEPTH];
   logic [AW-1:0] wr_ptr_r;
   logic [AW-1:0] rd_ptr_r;
   logic [NW-1:0] count_r;
   logic          overflow_r;
   logic          frame_done_r;

   logic          sof_s;
   logic          eol_s;
   logic          eof_s;
   logic          valid_s;
   logic          wr_s;
   logic          rd_s;
   logic [10:0]   head_s;
   logic [7:0]    out_data_s;
   logic          out_sof_s;
   logic          out_eol_s;
   logic          out_eof_s;

   // Position tags derived from the pre-increment counters.
   always_comb begin
      sof_s = (col_r == {CW{1'b0}}) && (row_r == {RW{1'b0}});
      eol_s = (col_r == COL_LAST);
      eof_s = (col_r == COL_LAST) && (row_r == ROW_LAST);
   end

   // FIFO handshake: a read frees a slot in the same cycle, so a full FIFO
   // being drained still accepts the incoming pixel.
   always_comb begin
      valid_s = (count_r != {NW{1'b0}});
      rd_s    = valid_s && m.m_ready;
      wr_s    = pixel_in_valid && ((count_r < FULL_CNT) || rd_s);
      head_s  = mem_r[rd_ptr_r];
   end

   // Output gating keeps data and tags at zero whenever no beat is offered.
   always_comb begin
      if (valid_s) begin
         out_data_s = head_s[10:3];
         out_sof_s  = head_s[2];
         out_eol_s  = head_s[1];
         out_eof_s  = head_s[0];
      end else begin
         out_data_s = 8'h00;
         out_sof_s  = 1'b0;
         out_eol_s  = 1'b0;
         out_eof_s  = 1'b0;
      end
   end

   assign m.m_data  = out_data_s;
   assign m.m_sof   = out_sof_s;
   assign m.m_eol   = out_eol_s;
   assign m.m_eof   = out_eof_s;
   assign m.m_valid = valid_s;
   assign overflow   = overflow_r;
   assign frame_done = frame_done_r;

   // Frame position counters; advance on every valid pixel, stored or not.
   always_ff @(posedge clk or negedge rstN) begin
      if (!rstN) begin
         col_r <= {CW{1'b0}};
         row_r <= {RW{1'b0}};
      end else if (pixel_in_valid) begin
         if (col_r == COL_LAST) begin
            col_r <= {CW{1'b0}};
            if (row_r == ROW_LAST) begin
               row_r <= {RW{1'b0}};
            end else begin
               row_r <= row_r + RW'(1);
            end
         end else begin
            col_r <= col_r + CW'(1);
         end
      end else begin
         col_r <= col_r;
         row_r <= row_r;
      end
   end

   // FIFO storage; contents are don't-care until written since the output
   // is gated by valid.
   always_ff @(posedge clk) begin
      if (wr_s) begin
         mem_r[wr_ptr_r] <= {pixel_in, sof_s, eol_s, eof_s};
      end
   end

   // FIFO pointers and occupancy; pointers wrap naturally (power-of-two depth).
   always_ff @(posedge clk or negedge rstN) begin
      if (!rstN) begin
         wr_ptr_r <= {AW{1'b0}};
         rd_ptr_r <= {AW{1'b0}};
         count_r  <= {NW{1'b0}};
      end else begin
         if (wr_s) begin
            wr_ptr_r <= wr_ptr_r + AW'(1);
         end else begin
            wr_ptr_r <= wr_ptr_r;
         end
         if (rd_s) begin
            rd_ptr_r <= rd_ptr_r + AW'(1);
         end else begin
            rd_ptr_r <= rd_ptr_r;
         end
         case ({wr_s, rd_s})
            2'b10:   count_r <= count_r + NW'(1);
            2'b01:   count_r <= count_r - NW'(1);
            default: count_r <= count_r;
         endcase
      end
   end

   // Sticky drop flag and end-of-frame transfer pulse.
   always_ff @(posedge clk or negedge rstN) begin
      if (!rstN) begin
         overflow_r   <= 1'b0;
         frame_done_r <= 1'b0;
      end else begin
         overflow_r   <= overflow_r | (pixel_in_valid & ~wr_s);
         frame_done_r <= rd_s & head_s[0];
      end
   end

`ifdef EDGE_COUNT_EN
   logic [ECW-1:0] run_r;
   logic [ECW-1:0] edge_count_r;
   logic           nz_s;

   assign nz_s       = (pixel_in != 8'h00);
   assign edge_count = edge_count_r;

   // Per-frame nonzero counter at the input side, so dropped pixels count too.
   always_ff @(posedge clk or negedge rstN) begin
      if (!rstN) begin
         run_r        <= {ECW{1'b0}};
         edge_count_r <= {ECW{1'b0}};
      end else if (pixel_in_valid) begin
         if (eof_s) begin
            edge_count_r <= run_r + ECW'(nz_s);
            run_r        <= {ECW{1'b0}};
         end else begin
            run_r        <= run_r + ECW'(nz_s);
            edge_count_r <= edge_count_r;
         end
      end else begin
         run_r        <= run_r;
         edge_count_r <= edge_count_r;
      end
   end
`else
   assign edge_count = {ECW{1'b0}};
`endif

endmodule

// File: doc/edge_frame_collector.md
# edge_frame_collector

Receive-side sink for the edge-detector output stream. Consumes the free-running `pixel_out`/`pixel_out_valid` stream of `canny_edge_top`, which has no backpressure, and tags each pixel with its position in an `IMG_W` x `IMG_H` frame. Pixels are buffered in a small FIFO and forwarded on a ready/valid interface with start-of-frame, end-of-line and end-of-frame markers, for a downstream host link or frame writer. Overflow is flagged, never silently hidden.

## Interface
- `IMG_W`, default 512: pixels per line.
- `IMG_H`, default 512: lines per frame.
- `FIFO_DEPTH`, default 16: entries, power of two, minimum 2.
- `clk`  in  1: single clock, rising edge.
- `rstN`  in  1: asynchronous, active-low reset.
- `pixel_in`  in  8: edge pixel from detector.
- `pixel_in_valid`  in  1: pixel_in valid this cycle. No backpressure is possible.
- `m_data`  out  8: output pixel.
- `m_sof`  out  1: m_data is pixel (row 0, col 0).
- `m_eol`  out  1: m_data is the last column of a line.
- `m_eof`  out  1: m_data is the last pixel of a frame (row IMG_H-1, col IMG_W-1).
- `m_valid`  out  1: output beat available.
- `m_ready`  in  1: downstream accepts.
- `overflow`  out  1: sticky; at least one input pixel was dropped.
- `frame_done`  out  1: one-cycle pulse after the m_eof beat transfers.
- `edge_count`  out  $clog2(IMG_W*IMG_H+1): nonzero pixels counted in the last complete input frame.

## Operation
- **Input counters**
  - `col` (width $clog2(IMG_W)) and `row` (width $clog2(IMG_H)) reset to 0.
  - Both advance on every cycle where `pixel_in_valid`=1, whether or not the pixel is stored.
  - `col` wraps IMG_W-1 to 0 and increments `row`; `row` wraps IMG_H-1 to 0.
- **Tagging:** each write stores {pixel, sof, eol, eof}, computed from the pre-increment `col`/`row`.
- **FIFO**
  - Show-ahead FIFO of FIFO_DEPTH x 11 bits, with an occupancy count of width $clog2(FIFO_DEPTH+1).
  - Write condition: `pixel_in_valid` && (count < FIFO_DEPTH || read this cycle).
  - Read condition: `m_valid` && `m_ready`.
  - Simultaneous read and write leaves the count unchanged.
- **Drop:** `pixel_in_valid` with the FIFO full and no read discards the pixel and sets `overflow`. Counters still advance, so later pixels keep their correct frame position.
- **Output:** `m_valid` = count != 0. `m_data` and the tags are the FIFO head. Head and tags hold stable while `m_valid` && !`m_ready`.
- **frame_done:** asserted the cycle after a transfer with `m_eof`=1.
- **overflow:** clears only on reset.

## Timing
- **Reset:** `m_data`=0, `m_sof`/`m_eol`/`m_eof`=0, `m_valid`=0, `overflow`=0, `frame_done`=0, `edge_count`=0, counters=0, FIFO empty.
- **Latency:** a pixel written at edge k appears on `m_valid`/`m_data` after edge k, one cycle, when the FIFO was empty.
- **Throughput:** 1 pixel/cycle sustained with `m_ready` held high; no overflow in that case.
- **Reset mid-frame:** FIFO flushed and counters zeroed asynchronously. The first pixel after release is tagged sof.
- **Degenerate sizes:** IMG_W=1 sets eol on every pixel. IMG_H=1 sets eof on every eol pixel.

## Configuration
- **`EDGE_COUNT_EN` defined:**
  - A running counter increments on each valid input pixel with `pixel_in` != 0, counting dropped pixels as well.
  - On the eof input pixel, `edge_count` <= running + (`pixel_in`!=0) and the running counter clears.
  - `edge_count` updates the cycle after the eof pixel is accepted at the input.
- **`EDGE_COUNT_EN` undefined:** no counter logic; `edge_count` is tied to 0.

## Test plan
Bench parameters: IMG_W=4, IMG_H=2, FIFO_DEPTH=4.
- **Basic frame:** reset, then 8 consecutive valid pixels 0x00..0x07 with `m_ready`=1.
  - Response: beats 0x00..0x07, each one cycle after input.
  - Markers: sof on 0x00; eol on 0x03 and 0x07; eof on 0x07.
  - `frame_done` pulses once; `overflow`=0.
- **Backpressure hold:** `m_ready`=0 for 3 cycles while pixels 0x10,0x11,0x12 arrive, then `m_ready`=1.
  - While stalled, `m_data` holds 0x10 with `m_valid`=1.
  - Then 0x10,0x11,0x12 drain in order and the FIFO ends empty.
- **Overflow:** `m_ready`=0 while 6 pixels 0xA0..0xA5 arrive.
  - `overflow` goes high on the 5th pixel.
  - After `m_ready`=1, output is 0xA0..0xA3 only.
  - The next input pixel (index 6) carries eol=0 and the one after it (index 7) carries eol=1 and eof=1, proving the counters kept advancing.
- **Async reset mid-frame:** assert `rstN`=0 after 3 pixels, between clock edges.
  - All outputs go to their reset values immediately.
  - The next pixel after release is tagged sof.
- **Edge count (`EDGE_COUNT_EN`):** frame pixels {0,255,0,255,255,0,0,255}.
  - `edge_count`=4 the cycle after the 8th pixel.
  - A following all-zero frame gives `edge_count`=0.
  - Without the macro, `edge_count` stays 0.
- **Back-to-back frames:** 16 continuous pixels with `m_ready`=1.
  - sof on beats 0 and 8; eof on beats 7 and 15.
  - `frame_done` pulses twice.
